// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_pipe
// Purpose  : RISC-V immediate decode stage behind a 2-entry skid buffer.
//            Optional per-format counters when IMM_PERF_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal
`ifdef IMM_PERF_CNT_EN
    ,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
`endif
);

    localparam logic [2:0] c_fmt_none = 3'd0;
    localparam logic [2:0] c_fmt_i    = 3'd1;
    localparam logic [2:0] c_fmt_s    = 3'd2;
    localparam logic [2:0] c_fmt_b    = 3'd3;
    localparam logic [2:0] c_fmt_u    = 3'd4;
    localparam logic [2:0] c_fmt_j    = 3'd5;
    localparam logic [2:0] c_fmt_z    = 3'd6;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    if ((XLEN != 32 && XLEN != 64) || CNT_W < 1) begin : g_param_check
        $error("imm_decode_pipe: XLEN must be 32 or 64 and CNT_W positive");
    end

    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    entry_t          w_new;
    logic            w_in_xfer;
    logic            w_out_xfer;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    // Every listed opcode ends in 2'b11, so non-32-bit encodings fall to default.
    always_comb begin
        w_fmt     = c_fmt_none;
        w_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111:                         w_fmt = c_fmt_u;
            7'b1101111:                                     w_fmt = c_fmt_j;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: w_fmt = c_fmt_i;
            7'b1100011:                                     w_fmt = c_fmt_b;
            7'b0100011:                                     w_fmt = c_fmt_s;
            7'b0110011:                                     w_fmt = c_fmt_none;
            7'b1110011: w_fmt = in_inst[14] ? c_fmt_z : c_fmt_i;
            7'b0011011: begin
                if (XLEN == 64) w_fmt = c_fmt_i;
                else            w_illegal = 1'b1;
            end
            7'b0111011: begin
                if (XLEN != 64) w_illegal = 1'b1;
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            c_fmt_i: w_imm = XLEN'($signed(in_inst[31:20]));
            c_fmt_s: w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            c_fmt_b: w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0}));
            c_fmt_u: w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            c_fmt_j: w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0}));
            c_fmt_z: w_imm = XLEN'(in_inst[19:15]);
            default: w_imm = '0;
        endcase
    end

    assign w_new      = '{inst: in_inst, pc: in_pc, imm: w_imm, fmt: w_fmt, illegal: w_illegal};
    assign w_in_xfer  = in_valid && in_ready_q;
    assign w_out_xfer = main_valid_q && out_ready;

    // Skid is only ever occupied while main is full, so input never races the skid move.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || w_out_xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_in_xfer) begin
                main_d       = w_new;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_in_xfer) begin
            skid_d       = w_new;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

`ifdef IMM_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [2:0]       w_cnt_idx;

    // Illegal entries carry fmt NONE, so they are steered to the dedicated slot 7.
    always_comb begin
        w_cnt_idx = main_q.illegal ? 3'd7 : main_q.fmt;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_out_xfer && (w_cnt_idx == 3'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt_val = cnt_q[cnt_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_decode_pipe
// Purpose  : Self-checking bench for imm_decode_pipe (XLEN=64 and XLEN=32 DUTs).
// Revision : 1.0
// ============================================================================
module tb_imm_decode_pipe;

    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_inst;
    logic [63:0] out_pc, out_imm;
    logic [2:0]  out_fmt;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_inst32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_inst [$];
    logic [63:0] q_pc   [$];

`ifdef IMM_PERF_CNT_EN
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val, cnt_val32;
`endif

    imm_decode_pipe #(.XLEN(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
`ifdef IMM_PERF_CNT_EN
        , .cnt_sel(cnt_sel), .cnt_val(cnt_val)
`endif
    );

    imm_decode_pipe #(.XLEN(32), .CNT_W(CNT_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_inst(out_inst32), .out_pc(out_pc32),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
`ifdef IMM_PERF_CNT_EN
        , .cnt_sel(cnt_sel), .cnt_val(cnt_val32)
`endif
    );

    always #5 clk = ~clk;

    // Reference decoder: immediates rebuilt from weighted instruction fields.
    function automatic void ref_decode(input logic [31:0] inst, input int xlen,
                                       output logic [2:0] fmt, output logic ill,
                                       output logic [63:0] imm);
        longint s, v;
        s = longint'($signed(inst));
        fmt = 3'd0; ill = 1'b0; v = 0;
        case (inst[6:0])
            7'h37, 7'h17:             fmt = 3'd4;
            7'h6F:                    fmt = 3'd5;
            7'h67, 7'h03, 7'h13, 7'h0F: fmt = 3'd1;
            7'h63:                    fmt = 3'd3;
            7'h23:                    fmt = 3'd2;
            7'h33:                    fmt = 3'd0;
            7'h73:                    fmt = inst[14] ? 3'd6 : 3'd1;
            7'h1B: if (xlen == 64) fmt = 3'd1; else ill = 1'b1;
            7'h3B: if (xlen != 64) ill = 1'b1;
            default:                  ill = 1'b1;
        endcase
        case (fmt)
            3'd1: v = s >>> 20;
            3'd2: v = (s >>> 25) * 32 + longint'(inst[11:7]);
            3'd3: v = (s >>> 31) * 4096 + longint'(inst[7]) * 2048
                      + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            3'd4: v = longint'($signed(inst & 32'hFFFF_F000));
            3'd5: v = (s >>> 31) * (64'sd1 << 20) + longint'(inst[19:12]) * 4096
                      + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            3'd6: v = longint'(inst[19:15]);
            default: v = 0;
        endcase
        imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opc [14];
        logic [31:0] r;
        int          pick;
        opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
                7'h63, 7'h23, 7'h33, 7'h73, 7'h1B, 7'h3B, 7'h73};
        r    = $urandom;
        pick = $urandom_range(0, 15);
        if (pick < 14) r[6:0] = opc[pick];
        return r;
    endfunction

    // Presents one instruction for a single cycle; caller sits on a negedge.
    task automatic push(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 64'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b r=%b imm=%h fmt=%0d ill=%b inst=%h pc=%h, expected all 0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_pc);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_before_edge: got %b expected 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || in_ready32 !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got r=%b r32=%b v=%b expected r=1 r32=1 v=0",
                     in_ready, in_ready32, out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] t_inst  [7] = '{32'hFFF00093, 32'h800000B7, 32'h008000EF, 32'h3401D073,
                                     32'h00000000, 32'h0010009B, 32'hFE112E23};
        logic [2:0]  t_fmt   [7] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd2};
        logic [2:0]  t_fmt32 [7] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0, 3'd2};
        logic        t_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        t_ill32 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [63:0] t_imm   [7] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_80000000, 64'd8, 64'd3,
                                     64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFC};
        logic [31:0] t_imm32 [7] = '{32'hFFFFFFFF, 32'h80000000, 32'd8, 32'd3,
                                     32'd0, 32'd0, 32'hFFFFFFFC};
        logic [63:0] pc;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(t_inst[i]);
            pc = in_pc;
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== t_inst[i] || out_pc !== pc ||
                out_fmt !== t_fmt[i] || out_imm !== t_imm[i] || out_illegal !== t_ill[i]) begin
                n_fail++;
                $display("FAIL decode64[%0d]: got v=%b inst=%h fmt=%0d imm=%h ill=%b, expected v=1 inst=%h fmt=%0d imm=%h ill=%b",
                         i, out_valid, out_inst, out_fmt, out_imm, out_illegal,
                         t_inst[i], t_fmt[i], t_imm[i], t_ill[i]);
            end
            n_checks++;
            if (out_valid32 !== 1'b1 || out_pc32 !== pc[31:0] || out_fmt32 !== t_fmt32[i] ||
                out_imm32 !== t_imm32[i] || out_illegal32 !== t_ill32[i]) begin
                n_fail++;
                $display("FAIL decode32[%0d]: got v=%b fmt=%0d imm=%h ill=%b, expected v=1 fmt=%0d imm=%h ill=%b",
                         i, out_valid32, out_fmt32, out_imm32, out_illegal32,
                         t_fmt32[i], t_imm32[i], t_ill32[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL decode_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h00100093, b = 32'h00200113, c = 32'h00300193;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = a; in_pc = 64'h100;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_inst !== a) begin
            n_fail++; $display("FAIL b2b_a_accept: got r=%b inst=%h expected r=1 inst=%h", in_ready, out_inst, a);
        end
        in_inst = b; in_pc = 64'h104;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || in_ready32 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_full: got r=%b r32=%b expected 0", in_ready, in_ready32);
        end
        in_inst = c; in_pc = 64'h108;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== a) begin
            n_fail++; $display("FAIL b2b_hold: got r=%b v=%b inst=%h expected r=0 v=1 inst=%h",
                               in_ready, out_valid, out_inst, a);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== b || out_pc !== 64'h104 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_b_out: got v=%b inst=%h pc=%h r=%b expected v=1 inst=%h pc=104 r=1",
                               out_valid, out_inst, out_pc, in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== c || out_inst32 !== c || out_pc !== 64'h108) begin
            n_fail++; $display("FAIL b2b_c_out: got v=%b inst=%h inst32=%h pc=%h expected v=1 inst=%h pc=108",
                               out_valid, out_inst, out_inst32, out_pc, c);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_empty: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(32'h00100093);
        push(32'h00200113);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0FF00213;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_valid32 !== 1'b0) begin
            n_fail++; $display("FAIL flush_two: got v=%b r=%b v32=%b expected v=0 r=1 v32=0",
                               out_valid, in_ready, out_valid32);
        end
        push(32'h00500293);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0AA00313;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL flush_one_cycle%0d: got v=%b r=%b inst=%h expected v=0 r=1",
                                   i, out_valid, in_ready, out_inst);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(32'hFFF00093);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got v=%b expected 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_pc, out_valid32} !== '0) begin
            n_fail++; $display("FAIL areset_async: got v=%b r=%b imm=%h inst=%h v32=%b expected all 0",
                               out_valid, in_ready, out_imm, out_inst, out_valid32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_recover: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
        end
    endtask

`ifdef IMM_PERF_CNT_EN
    task automatic test_perf();
        cnt_sel = 3'd1;
        out_ready = 1'b1;
        n_checks++;
        if (cnt_val !== 2'd0) begin
            n_fail++; $display("FAIL perf_init: got %0d expected 0", cnt_val);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_inst = 32'h00100093 + (i << 20);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cnt_val !== 2'd3 || cnt_val32 !== 2'd3) begin
            n_fail++; $display("FAIL perf_sat: got %0d/%0d expected 3", cnt_val, cnt_val32);
        end
        push(32'h00000000);
        @(negedge clk);
        cnt_sel = 3'd7;
        #1;
        n_checks++;
        if (cnt_val !== 2'd1) begin
            n_fail++; $display("FAIL perf_illegal: got %0d expected 1", cnt_val);
        end
        cnt_sel = 3'd0;
        #1;
        n_checks++;
        if (cnt_val !== 2'd0) begin
            n_fail++; $display("FAIL perf_illegal_not_none: got %0d expected 0", cnt_val);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cnt_sel = 3'd1;
        #1;
        n_checks++;
        if (cnt_val !== 2'd3) begin
            n_fail++; $display("FAIL perf_flush_i: got %0d expected 3", cnt_val);
        end
        cnt_sel = 3'd7;
        #1;
        n_checks++;
        if (cnt_val !== 2'd1) begin
            n_fail++; $display("FAIL perf_flush_ill: got %0d expected 1", cnt_val);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic        exp_valid, exp_rdy, in_x, out_x;
        logic [2:0]  f64, f32;
        logic        i64, i32;
        logic [63:0] m64, m32;
        q_inst.delete();
        q_pc.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_valid = (q_inst.size() > 0);
            exp_rdy   = (q_inst.size() < 2);
            n_checks++;
            if (out_valid !== exp_valid || in_ready !== exp_rdy ||
                out_valid32 !== exp_valid || in_ready32 !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_hs cyc%0d: got v=%b r=%b v32=%b r32=%b expected v=%b r=%b",
                         cyc, out_valid, in_ready, out_valid32, in_ready32, exp_valid, exp_rdy);
            end
            if (exp_valid) begin
                ref_decode(q_inst[0], 64, f64, i64, m64);
                ref_decode(q_inst[0], 32, f32, i32, m32);
                n_checks++;
                if (out_inst !== q_inst[0] || out_pc !== q_pc[0] || out_imm !== m64 ||
                    out_fmt !== f64 || out_illegal !== i64) begin
                    n_fail++;
                    $display("FAIL rand_data64 cyc%0d: got inst=%h pc=%h imm=%h fmt=%0d ill=%b expected inst=%h pc=%h imm=%h fmt=%0d ill=%b",
                             cyc, out_inst, out_pc, out_imm, out_fmt, out_illegal,
                             q_inst[0], q_pc[0], m64, f64, i64);
                end
                n_checks++;
                if (out_inst32 !== q_inst[0] || out_pc32 !== q_pc[0][31:0] ||
                    out_imm32 !== m32[31:0] || out_fmt32 !== f32 || out_illegal32 !== i32) begin
                    n_fail++;
                    $display("FAIL rand_data32 cyc%0d: got inst=%h imm=%h fmt=%0d ill=%b expected inst=%h imm=%h fmt=%0d ill=%b",
                             cyc, out_inst32, out_imm32, out_fmt32, out_illegal32,
                             q_inst[0], m32[31:0], f32, i32);
                end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            in_x  = in_valid && exp_rdy;
            out_x = exp_valid && out_ready;
            @(negedge clk);
            if (flush) begin
                q_inst.delete();
                q_pc.delete();
            end else begin
                if (out_x) begin
                    void'(q_inst.pop_front());
                    void'(q_pc.pop_front());
                end
                if (in_x) begin
                    q_inst.push_back(in_inst);
                    q_pc.push_back(in_pc);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef IMM_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
